// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 UART TX among N_REQ byte requesters; define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*8-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_err,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  input  logic               i_tx_done
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, rr_nxt, win, idx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] grant_nxt, ack_nxt;
  logic [7:0] data_nxt;
  logic err_nxt, start_nxt, timeout, req_any;
  assign req_any = |i_req;
  assign timeout = cnt == CW'(BUSY_TIMEOUT - 1);
  always_comb begin
    win = '0;
    idx = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'(i);
      win = i_req[idx] ? idx : win;
    end
`else
    for (int i = N_REQ; i >= 1; i--) begin
      idx = PW'((int'(rr_ptr) + i) % N_REQ);
      win = i_req[idx] ? idx : win;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= PW'(N_REQ - 1);
      cnt <= '0;
      o_grant <= '0;
      o_ack <= '0;
      o_err <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      rr_ptr <= rr_nxt;
      cnt <= cnt_nxt;
      o_grant <= grant_nxt;
      o_ack <= ack_nxt;
      o_err <= err_nxt;
      o_tx_start <= start_nxt;
      o_tx_data <= data_nxt;
    end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      state_nxt = req_any ? START : IDLE;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: state_nxt = i_tx_done ? IDLE : i_tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_nxt = i_tx_done ? IDLE : WAIT_DONE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    grant_nxt = o_grant;
    ack_nxt = '0;
    err_nxt = 1'b0;
    start_nxt = 1'b0;
    data_nxt = o_tx_data;
    rr_nxt = rr_ptr;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (req_any) begin
        grant_nxt = N_REQ'(1) << win;
        data_nxt = i_req_data[{win, 3'b000} +: 8];
        start_nxt = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
        rr_nxt = win;
`endif
      end
      START: cnt_nxt = '0;
      WAIT_BUSY: if (i_tx_done) begin
        ack_nxt = o_grant;
        grant_nxt = '0;
      end else if (!i_tx_busy) begin
        err_nxt = timeout;
        grant_nxt = timeout ? '0 : o_grant;
        cnt_nxt = timeout ? cnt : cnt + CW'(1);
      end
      WAIT_DONE: if (i_tx_done) begin
        ack_nxt = o_grant;
        grant_nxt = '0;
      end
      default: grant_nxt = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors plus randomized traffic against a transaction-level arbiter model
module tb_uart_tx_arbiter;
`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int BT = 16;
  logic clk, reset_n, i_tx_busy, i_tx_done, o_err, o_tx_start;
  logic [3:0] i_req, o_grant, o_ack;
  logic [7:0] rb[4];
  logic [7:0] o_tx_data;
  logic [31:0] i_req_data;
  int n_chk, n_fail;
  assign i_req_data = {rb[3], rb[2], rb[1], rb[0]};
  uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_req_data(i_req_data),
    .o_grant(o_grant), .o_ack(o_ack), .o_err(o_err), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy), .i_tx_done(i_tx_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] g_rr;
    logic [7:0] d_rr;
    logic [3:0] g_fx;
    logic [7:0] d_fx;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data(input logic [31:0] w);
    for (int k = 0; k < 4; k++) rb[k] = 8'(w >> (8 * k));
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    i_req = '0;
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  task automatic frame_start(input logic [3:0] eg, input logic [7:0] ed);
    step();
    chk("start", o_tx_start, 1);
    chk("grant", o_grant, eg);
    chk("data", o_tx_data, ed);
    chk("ack_at_start", o_ack, 0);
  endtask
  task automatic frame_finish(input logic [3:0] eg, input logic [7:0] ed, input int blen);
    step();
    chk("start_pulse", o_tx_start, 0);
    i_tx_busy = 1'b1;
    repeat (blen) begin
      step();
      chk("hold_grant", o_grant, eg);
      chk("hold_data", o_tx_data, ed);
      chk("no_early_ack", o_ack, 0);
    end
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    step();
    chk("ack", o_ack, eg);
    chk("grant_clear", o_grant, 0);
    chk("no_err", o_err, 0);
    i_tx_done = 1'b0;
  endtask
  function automatic int pick(input logic [3:0] r, input int l);
    if (FIXED) begin
      for (int i = 0; i < 4; i++) if (((r >> i) & 4'd1) != 0) return i;
    end else begin
      for (int i = 1; i <= 4; i++) if (((r >> ((l + i) % 4)) & 4'd1) != 0) return (l + i) % 4;
    end
    return -1;
  endfunction
  initial begin
    int owner, last, since, k, tx_t, tx_mode, tx_len;
    bit bseen, tx_act;
    logic [3:0] eg, ea;
    logic [7:0] md;
    logic ee, es;
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b1;
    i_req = '0;
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    set_data(32'h0);
    tv[0] = '{4'hF, 32'h44332211, 4'h1, 8'h11, 4'h1, 8'h11};
    tv[1] = '{4'hF, 32'h44332211, 4'h2, 8'h22, 4'h1, 8'h11};
    tv[2] = '{4'hF, 32'h44332211, 4'h4, 8'h33, 4'h1, 8'h11};
    tv[3] = '{4'hF, 32'h44332211, 4'h8, 8'h44, 4'h1, 8'h11};
    tv[4] = '{4'hF, 32'h44332211, 4'h1, 8'h11, 4'h1, 8'h11};
    tv[5] = '{4'hA, 32'hDEADBEEF, 4'h2, 8'hBE, 4'h2, 8'hBE};
    tv[6] = '{4'hA, 32'hDEADBEEF, 4'h8, 8'hDE, 4'h2, 8'hBE};
    tv[7] = '{4'h6, 32'h5A6B7C8D, 4'h2, 8'h7C, 4'h2, 8'h7C};
    tv[8] = '{4'h1, 32'h000000F0, 4'h1, 8'hF0, 4'h1, 8'hF0};
    tv[9] = '{4'h9, 32'h81000018, 4'h8, 8'h81, 4'h1, 8'h18};
    #3 reset_n = 1'b0;
    #1 chk("async_reset", {o_grant, o_ack, o_err, o_tx_start, o_tx_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (100) begin
      step();
      chk("idle_quiet", {o_grant, o_ack, o_err, o_tx_start, o_tx_data}, 0);
    end
    i_req = 4'b0001;
    set_data(32'h000000A5);
    frame_start(4'b0001, 8'hA5);
    frame_finish(4'b0001, 8'hA5, 2);
    i_req = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      i_req = tv[i].req;
      set_data(tv[i].data);
      frame_start(FIXED ? tv[i].g_fx : tv[i].g_rr, FIXED ? tv[i].d_fx : tv[i].d_rr);
      frame_finish(FIXED ? tv[i].g_fx : tv[i].g_rr, FIXED ? tv[i].d_fx : tv[i].d_rr, 1 + i % 3);
    end
    i_req = 4'b0001;
    set_data(32'h0000003C);
    frame_start(4'b0001, 8'h3C);
    repeat (BT) begin
      step();
      chk("to_no_err", o_err, 0);
      chk("to_grant", o_grant, 4'b0001);
    end
    step();
    chk("to_err", o_err, 1);
    chk("to_grant_clear", o_grant, 0);
    chk("to_no_ack", o_ack, 0);
    step();
    chk("to_err_pulse", o_err, 0);
    chk("retry_start", o_tx_start, 1);
    chk("retry_grant", o_grant, 4'b0001);
    frame_finish(4'b0001, 8'h3C, 2);
    i_req = 4'b0010;
    set_data(32'h00005500);
    frame_start(4'b0010, 8'h55);
    repeat (BT) step();
    i_tx_busy = 1'b1;
    step();
    chk("late_busy_no_err", o_err, 0);
    chk("late_busy_grant", o_grant, 4'b0010);
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    step();
    chk("late_busy_ack", o_ack, 4'b0010);
    i_tx_done = 1'b0;
    i_req = 4'b1000;
    set_data(32'hC3000000);
    frame_start(4'b1000, 8'hC3);
    step();
    i_tx_busy = 1'b1;
    repeat (2) step();
    chk("pre_rst_grant", o_grant, 4'b1000);
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_outputs", {o_grant, o_ack, o_err, o_tx_start, o_tx_data}, 0);
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    step();
    chk("rst_no_ack", o_ack, 0);
    i_tx_done = 1'b0;
    i_req = 4'b0110;
    set_data(32'h0000EE00);
    step();
    reset_n = 1'b1;
    frame_start(4'b0010, 8'hEE);
    frame_finish(4'b0010, 8'hEE, 1);
    i_req = 4'b0100;
    set_data(32'h00770000);
    frame_start(4'b0100, 8'h77);
    i_req = '0;
    set_data(32'h00990000);
    frame_finish(4'b0100, 8'h77, 3);
    i_req = 4'b0001;
    set_data(32'h00000042);
    frame_start(4'b0001, 8'h42);
    step();
    i_tx_done = 1'b1;
    step();
    chk("done_in_wait_busy_ack", o_ack, 4'b0001);
    chk("done_in_wait_busy_grant", o_grant, 0);
    i_tx_done = 1'b0;
    i_req = '0;
    repeat (5) begin
      step();
      chk("idle_hold_data", o_tx_data, 8'h42);
      chk("idle_no_pulse", {o_grant, o_ack, o_err, o_tx_start}, 0);
    end
    do_reset();
    set_data(32'h0);
    owner = -1;
    last = 3;
    since = 0;
    bseen = 0;
    md = 8'h00;
    tx_act = 0;
    tx_t = 0;
    tx_mode = 0;
    tx_len = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      ea = '0;
      ee = 1'b0;
      es = 1'b0;
      if (owner < 0) begin
        if (i_req != 0) begin
          k = pick(i_req, last);
          owner = k;
          since = 0;
          bseen = 0;
          es = 1'b1;
          md = rb[k];
          if (!FIXED) last = k;
        end
      end else if (since == 0) since = 1;
      else if (i_tx_done) begin
        ea = 4'(1 << owner);
        owner = -1;
      end else if (bseen) ;
      else if (i_tx_busy) bseen = 1;
      else if (since == BT) begin
        ee = 1'b1;
        owner = -1;
      end else since++;
      eg = owner < 0 ? 4'h0 : 4'(1 << owner);
      chk("rnd_grant", o_grant, eg);
      chk("rnd_ack", o_ack, ea);
      chk("rnd_err", o_err, ee);
      chk("rnd_start", o_tx_start, es);
      chk("rnd_data", o_tx_data, md);
      i_tx_busy = 1'b0;
      i_tx_done = 1'b0;
      if (tx_act) begin
        tx_t++;
        if (tx_mode >= 3) begin
          if (tx_t <= tx_len) i_tx_busy = 1'b1;
          else begin
            i_tx_done = 1'b1;
            tx_act = 0;
          end
        end else if (tx_mode == 2 && tx_t == tx_len) begin
          i_tx_done = 1'b1;
          tx_act = 0;
        end
      end
      if (o_tx_start) begin
        tx_act = 1;
        tx_t = 0;
        tx_mode = $urandom_range(0, 9);
        tx_len = $urandom_range(1, 6);
      end
      for (int j = 0; j < 4; j++) begin
        if (o_ack[2'(j)]) begin
          i_req[2'(j)] = 1'($urandom_range(0, 1));
          rb[j] = 8'($urandom);
        end else if (!i_req[2'(j)] && $urandom_range(0, 3) == 0) begin
          i_req[2'(j)] = 1'b1;
          rb[j] = 8'($urandom);
        end else if (o_grant[2'(j)] && $urandom_range(0, 15) == 0) i_req[2'(j)] = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
